md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multi-cycle multiply/divide unit that lives in the Execute stage, directly downstream of the Decode stage.
- Takes forwarded rs/rt operands and a decoded MD operation; owns the architectural HI/LO registers.
- Raises a stall request so Decode holds any MD-class instruction while an operation is in flight.
- Serves mfhi/mflo reads combinationally to the E-stage result mux.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >=1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- md_op  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 treated as none.
- start  input  1  qualifies md_op as a real E-stage instruction (low for bubbles).
- A  input  32  rs operand, forwarded.
- B  input  32  rt operand, forwarded.
- busy  output  1  operation in progress.
- h_md  output  1  stall request to the hazard unit: busy | (start & md_op in 1..4).
- HI  output  32  architectural HI.
- LO  output  32  architectural LO.
- md_out  output  32  HI when md_op==7, LO when md_op==8, else 0; combinational.

Behaviour:
- Reset (async, any time, including mid-operation): HI=0, LO=0, busy=0, counter=0, latched operands/op cleared; in-flight result discarded. Outputs valid immediately, without waiting for a clock edge.
- Accept rule: an op is accepted on a rising edge only when start=1 and busy=0. start while busy=1 is ignored with no state change; the hazard unit must never issue this.
- mult/multu/div/divu accept edge:
  - latch A, B and op;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - set busy=1.
- Each subsequent edge with counter>1: decrement counter.
- Edge with counter==1: write HI/LO, counter=0, busy=0.
- Net timing: busy is high for exactly N cycles, and the new HI/LO is visible on the same cycle busy falls.
- mthi/mtlo: HI<=A or LO<=A on the accept edge; busy stays 0 (single cycle).
- mfhi/mflo and none: no state change. md_out reflects current HI/LO; during busy it shows pre-op values, because the hazard unit stalls readers.
- Arithmetic:
  - mult: {HI,LO} = signed(A)*signed(B), full 64 bits.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - div special case: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient to LO, unsigned remainder to HI.
- Divide by zero (B==0 at accept): full DIV_CYCLES of busy still elapse; HI and LO remain unchanged at completion.
- Results are computed from the operands latched at accept. Later changes on A/B during busy have no effect.
- Back-to-back: a new MD op may be accepted on the edge right after busy falls.
- No internal flush input; cancellation is by reset only.

Test Plan:
- mult with A=0xFFFFFFFE, B=3, start for 1 cycle:
  - busy high exactly 5 cycles, h_md high from the start cycle;
  - then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu with A=0xFFFFFFFE, B=3: HI=0x00000002, LO=0xFFFFFFFA after 5 busy cycles.
- div, then divu:
  - div A=0xFFFFFFF9, B=2: after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu with same operands: LO=0x7FFFFFFC, HI=0x00000001.
- Divide by zero:
  - setup: mthi A=0x11, mtlo A=0x22;
  - div with B=0: busy 10 cycles, HI=0x11 and LO=0x22 afterwards.
- Moves and ignored start:
  - mthi A=0x1234 with busy low, then md_op=7: md_out=0x1234 next cycle, busy never asserted.
  - start a mult, then pulse start+mtlo on busy cycle 2: LO equals the mult result only, and the mtlo is ignored.
- Reset mid-operation:
  - start div, assert reset between clock edges on busy cycle 4: busy, HI, LO go to 0 immediately.
  - after release, mult A=7, B=6 completes with LO=42, HI=0 after 5 cycles.

Source files
------------

// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - signal bundle between the E stage and the multiply/divide unit
//
// Purpose : groups the operation request, forwarded operands and the unit's
//           status/result outputs so they travel as one port.
// Signals : md_op  - decoded MD operation (0 none, 1 mult, 2 multu, 3 div,
//                    4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 none)
//           start  - md_op is a real instruction (low for bubbles)
//           A, B   - forwarded rs / rt operands
//           busy   - multi-cycle operation in flight
//           h_md   - stall request to the hazard unit
//           HI, LO - architectural HI/LO registers
//           md_out - combinational mfhi/mflo read data
// Modports: master drives the request side (E stage), slave is the unit.
interface md_unit_if;
   logic [3:0]  md_op;
   logic        start;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        h_md;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] md_out;

   modport master (
      output md_op, start, A, B,
      input  busy, h_md, HI, LO, md_out
   );

   modport slave (
      input  md_op, start, A, B,
      output busy, h_md, HI, LO, md_out
   );
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle multiply/divide unit owning HI/LO
//
// Purpose : executes mult/multu/div/divu over a fixed number of busy cycles,
//           handles mthi/mtlo in one cycle and serves mfhi/mflo reads
//           combinationally. Raises h_md so Decode holds MD-class work while
//           an operation is in flight.
// Ports   : clk   - rising-edge clock
//           reset - asynchronous active-high, clears all state
//           md    - md_unit_if.slave (md_op, start, A, B in;
//                   busy, h_md, HI, LO, md_out out)
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic     clk,
   input  logic     reset,
   md_unit_if.slave md
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  count, count_nxt;
   logic [31:0]    a_q, b_q;
   logic [3:0]     op_q;
   logic [31:0]    hi, lo;
   logic [31:0]    hi_nxt, lo_nxt;
   logic           hi_we, lo_we;
   logic           long_op;
   logic           accept_long;
   logic [63:0]    res;
   logic           res_ok;
   logic signed [31:0] sa, sb;
   logic signed [63:0] prod_s;
   logic [63:0]    prod_u;

   assign long_op     = (md.md_op >= OP_MULT) && (md.md_op <= OP_DIVU);
   assign accept_long = (state == S_IDLE) && md.start && long_op;

   // Arithmetic works only on the operands latched at accept, so the
   // forwarding paths may change freely while busy.
   assign sa     = a_q;
   assign sb     = b_q;
   assign prod_s = $signed({{32{sa[31]}}, sa}) * $signed({{32{sb[31]}}, sb});
   assign prod_u = {32'd0, a_q} * {32'd0, b_q};

   always_comb begin
      res    = '0;
      res_ok = 1'b1;
      case (op_q)
         OP_MULT:  res = prod_s;
         OP_MULTU: res = prod_u;
         OP_DIV: begin
            if (b_q == 32'd0) begin
               res_ok = 1'b0;
            end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
               // Quotient overflows; pin the result instead of relying on
               // the divider's wraparound behaviour.
               res = {32'd0, 32'h8000_0000};
            end else begin
               // SV signed / truncates toward zero and % takes the
               // dividend's sign, which is exactly the required semantics.
               res = {32'(sa % sb), 32'(sa / sb)};
            end
         end
         OP_DIVU: begin
            if (b_q == 32'd0) res_ok = 1'b0;
            else              res = {a_q % b_q, a_q / b_q};
         end
         default: res_ok = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      hi_we     = 1'b0;
      lo_we     = 1'b0;
      hi_nxt    = md.A;
      lo_nxt    = md.A;
      case (state)
         S_IDLE: begin
            if (md.start) begin
               case (md.md_op)
                  OP_MULT, OP_MULTU: begin
                     state_nxt = S_BUSY;
                     count_nxt = CW'(MULT_CYCLES);
                  end
                  OP_DIV, OP_DIVU: begin
                     state_nxt = S_BUSY;
                     count_nxt = CW'(DIV_CYCLES);
                  end
                  OP_MTHI: hi_we = 1'b1;
                  OP_MTLO: lo_we = 1'b1;
                  default: ;
               endcase
            end
         end
         S_BUSY: begin
            // start while busy is deliberately ignored here.
            if (count == CW'(1)) begin
               state_nxt = S_IDLE;
               count_nxt = '0;
               hi_we     = res_ok;
               lo_we     = res_ok;
               hi_nxt    = res[63:32];
               lo_nxt    = res[31:0];
            end else begin
               count_nxt = count - CW'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         count <= '0;
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= '0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         if (accept_long) begin
            a_q  <= md.A;
            b_q  <= md.B;
            op_q <= md.md_op;
         end
         if (hi_we) hi <= hi_nxt;
         if (lo_we) lo <= lo_nxt;
      end
   end

   assign md.busy = (state == S_BUSY);
   assign md.h_md = md.busy | (md.start & long_op);
   assign md.HI   = hi;
   assign md.LO   = lo;

   always_comb begin
      case (md.md_op)
         OP_MFHI: md.md_out = hi;
         OP_MFLO: md.md_out = lo;
         default: md.md_out = '0;
      endcase
   end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit
module tb_md_unit;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;

   md_unit_if mif ();

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .md    (mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } vec_t;

   vec_t vecs [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called in the low clock phase; the next rising edge is the accept edge.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n);
      mif.start = 1'b1;
      mif.md_op = op;
      mif.A     = a;
      mif.B     = b;
      #1;
      chk("h_md_at_start", 32'(mif.h_md), 32'((op >= 4'd1 && op <= 4'd4) ? 1 : 0));
      @(negedge clk);
      mif.start = 1'b0;
      mif.md_op = 4'd0;
      mif.A     = $urandom;
      mif.B     = $urandom;
      n = 0;
      while (mif.busy && n < 60) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      int n;
      n_cmp = 0;
      n_bad = 0;

      vecs[0]  = '{4'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
      vecs[1]  = '{4'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
      vecs[2]  = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
      vecs[3]  = '{4'd4, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10};
      vecs[4]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
      vecs[5]  = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
      vecs[6]  = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
      vecs[7]  = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
      vecs[8]  = '{4'd5, 32'h1234,     32'd0,        32'h00001234, 32'h00000001, 0};
      vecs[9]  = '{4'd6, 32'h55,       32'd0,        32'h00001234, 32'h00000055, 0};
      vecs[10] = '{4'd1, 32'd7,        32'd6,        32'h00000000, 32'h0000002A, 5};
      vecs[11] = '{4'd5, 32'h11,       32'd0,        32'h00000011, 32'h0000002A, 0};
      vecs[12] = '{4'd6, 32'h22,       32'd0,        32'h00000011, 32'h00000022, 0};
      vecs[13] = '{4'd3, 32'd5,        32'd0,        32'h00000011, 32'h00000022, 10};
      vecs[14] = '{4'd4, 32'd9,        32'd0,        32'h00000011, 32'h00000022, 10};
      vecs[15] = '{4'd7, 32'h9999,     32'd0,        32'h00000011, 32'h00000022, 0};
      vecs[16] = '{4'd15, 32'd1,       32'd1,        32'h00000011, 32'h00000022, 0};

      reset     = 1'b1;
      mif.start = 1'b0;
      mif.md_op = 4'd0;
      mif.A     = '0;
      mif.B     = '0;
      #1;
      chk("reset_busy", 32'(mif.busy), 32'd0);
      chk("reset_h_md", 32'(mif.h_md), 32'd0);
      chk("reset_HI",   mif.HI, 32'd0);
      chk("reset_LO",   mif.LO, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Each op is issued in the cycle right after the previous busy falls.
      for (int i = 0; i < 17; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
         chk($sformatf("v%0d_cycles", i), 32'(n), 32'(vecs[i].cyc));
         chk($sformatf("v%0d_HI", i), mif.HI, vecs[i].hi);
         chk($sformatf("v%0d_LO", i), mif.LO, vecs[i].lo);
         mif.md_op = 4'd7;
         #1;
         chk($sformatf("v%0d_mfhi", i), mif.md_out, vecs[i].hi);
         mif.md_op = 4'd8;
         #1;
         chk($sformatf("v%0d_mflo", i), mif.md_out, vecs[i].lo);
         mif.md_op = 4'd0;
         #1;
      end

      // Reset between edges on busy cycle 4 of a div.
      @(negedge clk);
      mif.start = 1'b1;
      mif.md_op = 4'd3;
      mif.A     = 32'd100;
      mif.B     = 32'd7;
      @(negedge clk);
      mif.start = 1'b0;
      mif.md_op = 4'd0;
      chk("rst_mid_busy_before", 32'(mif.busy), 32'd1);
      repeat (3) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_mid_busy", 32'(mif.busy), 32'd0);
      chk("rst_mid_HI",   mif.HI, 32'd0);
      chk("rst_mid_LO",   mif.LO, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_op(4'd1, 32'd7, 32'd6, n);
      chk("post_rst_cycles", 32'(n), 32'd5);
      chk("post_rst_HI", mif.HI, 32'd0);
      chk("post_rst_LO", mif.LO, 32'd42);

      // mtlo presented on busy cycle 2 of a mult must be dropped.
      mif.start = 1'b1;
      mif.md_op = 4'd1;
      mif.A     = 32'd3;
      mif.B     = 32'd5;
      @(negedge clk);
      n = 0;
      while (mif.busy && n < 60) begin
         n++;
         if (n == 2) begin
            chk("ign_h_md_busy", 32'(mif.h_md), 32'd1);
            mif.start = 1'b1;
            mif.md_op = 4'd6;
            mif.A     = 32'hDEAD;
         end else begin
            mif.start = 1'b0;
            mif.md_op = 4'd0;
            mif.A     = 32'd0;
         end
         @(negedge clk);
      end
      mif.start = 1'b0;
      mif.md_op = 4'd0;
      chk("ign_cycles", 32'(n), 32'd5);
      chk("ign_HI", mif.HI, 32'd0);
      chk("ign_LO", mif.LO, 32'd15);
      @(negedge clk);
      chk("ign_LO_after", mif.LO, 32'd15);
      chk("ign_busy_after", 32'(mif.busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
